// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: decode-bus register, one-hot ALU, HI/LO and a 32-step restoring divider
module ex_stage #(
   parameter int STALL_W     = 6,
   parameter int ID_TO_EX_W  = 159,
   parameter int EX_TO_MEM_W = 76
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_W-1:0]     stall,
   input  logic [ID_TO_EX_W-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
   output logic [37:0]            ex_to_id_forwarding,
   output logic                   data_sram_en,
   output logic [3:0]             data_sram_wen,
   output logic [31:0]            data_sram_addr,
   output logic [31:0]            data_sram_wdata,
   output logic                   stallreq
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

   logic [ID_TO_EX_W-1:0] bus_q, bus_d;
   div_state_e            state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [31:0]           quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [31:0]           hi_q, hi_d, lo_q, lo_d;
   logic                  qneg_q, qneg_d, rneg_q, rneg_d;
   logic                  done_q, done_d;

   logic [31:0] pc, inst, rdata1, rdata2;
   logic [11:0] alu_op;
   logic [2:0]  sel_src1;
   logic [3:0]  sel_src2, ram_wen;
   logic        ram_en, rf_we, sel_rf_res;
   logic [4:0]  rf_waddr;

   assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
           rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = bus_q;

   logic op_zero, is_mfhi, is_mflo, is_div, is_divu, div_start;
   assign op_zero   = (inst[31:26] == 6'h00);
   assign is_mfhi   = op_zero && (inst[5:0] == 6'h10);
   assign is_mflo   = op_zero && (inst[5:0] == 6'h12);
   assign is_div    = op_zero && (inst[5:0] == 6'h1A);
   assign is_divu   = op_zero && (inst[5:0] == 6'h1B);
   // done_q keeps a finished divide from restarting while it is still held in EX
   assign div_start = (state_q == IDLE) && (is_div || is_divu) && !done_q;
   assign stallreq  = div_start || (state_q == RUN);

   logic [31:0] src1, src2, sra_res, alu_res, ex_result;
   logic        slt_lt;
   assign src1 = ({32{sel_src1[2]}} & {27'd0, inst[10:6]})
               | ({32{sel_src1[1]}} & pc)
               | ({32{sel_src1[0]}} & rdata1);
   assign src2 = ({32{sel_src2[3]}} & {16'd0, inst[15:0]})
               | ({32{sel_src2[2]}} & 32'd8)
               | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
               | ({32{sel_src2[0]}} & rdata2);
   assign sra_res = $signed(src2) >>> src1[4:0];
   assign slt_lt  = $signed(src1) < $signed(src2);

   assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                  | ({32{alu_op[10]}} & (src1 - src2))
                  | ({32{alu_op[9]}}  & {31'd0, slt_lt})
                  | ({32{alu_op[8]}}  & {31'd0, (src1 < src2)})
                  | ({32{alu_op[7]}}  & (src1 & src2))
                  | ({32{alu_op[6]}}  & ~(src1 | src2))
                  | ({32{alu_op[5]}}  & (src1 | src2))
                  | ({32{alu_op[4]}}  & (src1 ^ src2))
                  | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                  | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                  | ({32{alu_op[1]}}  & sra_res)
                  | ({32{alu_op[0]}}  & {src2[15:0], 16'd0});

   assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

   logic [32:0] rem_sh;
   logic [31:0] diff;
   logic        take;
   assign rem_sh = {rem_q, quo_q[31]};
   assign take   = (rem_sh >= {1'b0, dvs_q});
   assign diff   = rem_sh[31:0] - dvs_q;

   always_comb begin
      bus_d = bus_q;
      if (stall[2] && !stall[3]) bus_d = '0;
      else if (!stall[2])        bus_d = id_to_ex_bus;

      done_d = done_q;
      if (!stall[2] || !stall[3]) done_d = 1'b0;
      else if (state_q == DONE)   done_d = 1'b1;

      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: if (div_start) begin
            quo_d   = (is_div && rdata1[31]) ? -rdata1 : rdata1;
            dvs_d   = (is_div && rdata2[31]) ? -rdata2 : rdata2;
            rem_d   = '0;
            qneg_d  = is_div && (rdata1[31] ^ rdata2[31]);
            rneg_d  = is_div && rdata1[31];
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            quo_d = {quo_q[30:0], take};
            rem_d = take ? diff : rem_sh[31:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DONE;
         end
         DONE: begin
            lo_d    = qneg_q ? -quo_q : quo_q;
            hi_d    = rneg_q ? -rem_q : rem_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_q   <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         bus_q   <= bus_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign ex_to_mem_bus = {pc, ram_en & ~stallreq, ram_wen & {4{~stallreq}}, sel_rf_res,
                           rf_we & ~stallreq, rf_waddr, ex_result};
   assign ex_to_id_forwarding = {rf_we & ~sel_rf_res & ~stallreq, rf_waddr, ex_result};
   assign data_sram_en    = ram_en & ~stallreq;
   assign data_sram_wen   = ram_wen & {4{~stallreq}};
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = rdata2;

   logic unused_bits;
   assign unused_bits = ^{stall[STALL_W-1:4], stall[1:0], inst[25:16]};

endmodule
